pc_flow_ctrl: RTL and testbench

Multicycle next-PC sequencer that drives the PCSource mux select, the PC write enable and the ALU operand/operation selects needed to compute the next PC. The main control FSM hands it one instruction per `start` pulse. It performs fetch-increment, branch-target precompute, the branch compare, jump and jump-register updates, then returns `done`. It is the producer side of the PCSource interface: its `pc_source` output feeds the PCSource mux select directly.

---
 rtl/pc_flow_pkg.sv | 56 +++++
 rtl/pc_flow_ctrl_if.sv | 30 +++
 rtl/pc_flow_ctrl_branch_cond.sv | 23 ++
 rtl/pc_flow_ctrl.sv | 105 ++++++++++
 tb/tb_pc_flow_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_flow_pkg.sv
// Shared encodings for the next-PC sequencer and the PCSource mux it drives.
package pc_flow_pkg;

  localparam int unsigned OPCODE_W    = 6;
  localparam int unsigned PCSRC_W     = 2;
  localparam int unsigned ALU_SRC_B_W = 2;
  localparam int unsigned ALU_OP_W    = 3;
  localparam int unsigned STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_BRANCH = 3'd3,
    ST_JUMP   = 3'd4,
    ST_JR     = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_BLE   = 6'h06;
  localparam logic [OPCODE_W-1:0] OP_BGT   = 6'h07;
  localparam logic [OPCODE_W-1:0] FUNCT_JR = 6'h08;

  localparam logic [ALU_OP_W-1:0] ALU_PASS_A = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'b010;

  localparam logic [ALU_SRC_B_W-1:0] SRC_B_REG  = 2'b00;
  localparam logic [ALU_SRC_B_W-1:0] SRC_B_FOUR = 2'b01;
  localparam logic [ALU_SRC_B_W-1:0] SRC_B_IMM  = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b10;

  // Flow-control class of the instruction being decoded, as the state that follows DECODE.
  function automatic state_e decode_next(input logic [OPCODE_W-1:0] opcode,
                                         input logic [OPCODE_W-1:0] funct);
    state_e nxt;
    nxt = ST_DONE;
    if (opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_BLE || opcode == OP_BGT) begin
      nxt = ST_BRANCH;
    end else if (opcode == OP_J || opcode == OP_JAL) begin
      nxt = ST_JUMP;
    end else if (opcode == OP_RTYPE && funct == FUNCT_JR) begin
      nxt = ST_JR;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// Handshake, instruction fields, ALU flags and PC/ALU control outputs of the sequencer.
interface pc_flow_ctrl_if;
  import pc_flow_pkg::*;

  logic                   start;
  logic [OPCODE_W-1:0]    opcode;
  logic [OPCODE_W-1:0]    funct;
  logic                   zero;
  logic                   gt;
  logic [PCSRC_W-1:0]     pc_source;
  logic                   pc_write;
  logic                   alu_src_a;
  logic [ALU_SRC_B_W-1:0] alu_src_b;
  logic [ALU_OP_W-1:0]    alu_op;
  logic                   aluout_write;
  logic                   busy;
  logic                   done;

  // Main control / datapath side.
  modport master (
    output start, opcode, funct, zero, gt,
    input  pc_source, pc_write, alu_src_a, alu_src_b, alu_op, aluout_write, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, opcode, funct, zero, gt,
    output pc_source, pc_write, alu_src_a, alu_src_b, alu_op, aluout_write, busy, done
  );
endinterface

// File: rtl/pc_flow_ctrl_branch_cond.sv
// Branch-taken decision from the opcode and the live ALU compare flags.
module branch_cond
  import pc_flow_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                gt,
  output logic                take
);

  // Condition per branch flavour; non-branch opcodes never take.
  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_BEQ:  take = zero;
      OP_BNE:  take = ~zero;
      OP_BLE:  take = zero | ~gt;
      OP_BGT:  take = gt;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Multicycle next-PC sequencer: fetch increment, branch target precompute, branch/jump/JR update.
module pc_flow_ctrl
  import pc_flow_pkg::*;
#(
  parameter logic [ALU_SRC_B_W-1:0] PC_INC_SEL = SRC_B_FOUR
) (
  input  logic               clk,
  input  logic               reset,
  pc_flow_ctrl_if.slave      bus
);

  state_e                 state_q, state_d;
  logic                   take;
  logic [PCSRC_W-1:0]     pc_source;
  logic                   pc_write;
  logic                   alu_src_a;
  logic [ALU_SRC_B_W-1:0] alu_src_b;
  logic [ALU_OP_W-1:0]    alu_op;
  logic                   aluout_write;
  logic                   busy;
  logic                   done;

  branch_cond u_branch_cond (
    .opcode (bus.opcode),
    .zero   (bus.zero),
    .gt     (bus.gt),
    .take   (take)
  );

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded controls; only the BRANCH pc_write looks at the flags.
  always_comb begin
    state_d      = state_q;
    pc_source    = PCSRC_JUMP;
    pc_write     = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_REG;
    alu_op       = ALU_PASS_A;
    aluout_write = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        alu_src_b = PC_INC_SEL;
        alu_op    = ALU_ADD;
        pc_source = PCSRC_ALU;
        pc_write  = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
        state_d      = decode_next(bus.opcode, bus.funct);
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = take;
        state_d   = ST_DONE;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        state_d  = ST_DONE;
      end
      ST_JR: begin
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALU;
        pc_write  = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = bus.start ? ST_FETCH : ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.pc_source    = pc_source;
  assign bus.pc_write     = pc_write;
  assign bus.alu_src_a    = alu_src_a;
  assign bus.alu_src_b    = alu_src_b;
  assign bus.alu_op       = alu_op;
  assign bus.aluout_write = aluout_write;
  assign bus.busy         = busy;
  assign bus.done         = done;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed scenarios plus randomized instruction stream.
module tb_pc_flow_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pc_flow_ctrl_if bus();

  pc_flow_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Output vector: {pc_source, pc_write, alu_src_a, alu_src_b, alu_op, aluout_write, busy, done}
  localparam logic [11:0] V_IDLE   = 12'b00_0_0_00_000_0_0_0;
  localparam logic [11:0] V_FETCH  = 12'b01_1_0_01_001_0_1_0;
  localparam logic [11:0] V_DECODE = 12'b00_0_0_11_001_1_1_0;
  localparam logic [11:0] V_BR_T   = 12'b10_1_1_00_010_0_1_0;
  localparam logic [11:0] V_BR_N   = 12'b10_0_1_00_010_0_1_0;
  localparam logic [11:0] V_JUMP   = 12'b00_1_0_00_000_0_1_0;
  localparam logic [11:0] V_JR     = 12'b01_1_1_00_000_0_1_0;
  localparam logic [11:0] V_DONE   = 12'b00_0_0_00_000_0_1_1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: position within the current instruction (0 = idle), its class and its length in cycles.
  int m_pos = 0;
  int m_cls = 0;   // 0 plain, 1 branch, 2 jump, 3 jr
  int m_len = 3;

  logic [11:0] obs;
  logic [11:0] exp_v;

  function automatic logic cond_taken(input logic [5:0] op, input logic z, input logic g);
    case (op)
      6'h04:   return z;
      6'h05:   return !z;
      6'h06:   return z || !g;
      6'h07:   return g;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op >= 6'h04 && op <= 6'h07) return 1;
    if (op == 6'h02 || op == 6'h03) return 2;
    if (op == 6'h00 && fn == 6'h08) return 3;
    return 0;
  endfunction

  function automatic logic [11:0] model_out(input logic rst_n, input logic [5:0] op,
                                            input logic z, input logic g);
    if (!rst_n || m_pos == 0) return V_IDLE;
    if (m_pos == 1) return V_FETCH;
    if (m_pos == 2) return V_DECODE;
    if (m_pos == m_len) return V_DONE;
    case (m_cls)
      1:       return cond_taken(op, z, g) ? V_BR_T : V_BR_N;
      2:       return V_JUMP;
      default: return V_JR;
    endcase
  endfunction

  // One clock: drive inputs after the falling edge, compare against the model, then advance it.
  task automatic tick(input logic rst_n, input logic st, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic g);
    @(negedge clk);
    reset      = rst_n;
    bus.start  = st;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    bus.gt     = g;
    #2;
    obs = {bus.pc_source, bus.pc_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
           bus.aluout_write, bus.busy, bus.done};
    exp_v = model_out(rst_n, op, z, g);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL model cyc=%0d op=%h z=%b g=%b got=%b want=%b", cyc, op, z, g, obs, exp_v);
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_pos = 0;
    end else if (m_pos == 0 || m_pos == m_len) begin
      m_pos = st ? 1 : 0;
    end else begin
      if (m_pos == 2) begin
        m_cls = classify(op, fn);
        m_len = (m_cls == 0) ? 3 : 4;
      end
      m_pos++;
    end
  endtask

  task automatic chk_lit(input string name, input logic [11:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, obs, want);
    end
  endtask

  // Start from IDLE, run one flow instruction and pin its execute cycle and the DONE cycle.
  task automatic run_flow(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic g, input logic [11:0] want3);
    tick(1'b1, 1'b1, op, fn, 1'b0, 1'b0);
    tick(1'b1, 1'b0, op, fn, 1'b0, 1'b0);
    chk_lit({name, "_c1"}, V_FETCH);
    tick(1'b1, 1'b0, op, fn, 1'b0, 1'b0);
    tick(1'b1, 1'b0, op, fn, z, g);
    chk_lit({name, "_c3"}, want3);
    tick(1'b1, 1'b0, op, fn, 1'b0, 1'b0);
    chk_lit({name, "_c4_done"}, V_DONE);
  endtask

  logic [5:0] op_pool [10];
  logic [5:0] swp_op  [3];
  logic [3:0] swp_tk  [3];

  initial begin
    logic [5:0] op, fn;
    logic [3:0] tk;
    logic       st, rn;

    op_pool = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03, 6'h00, 6'h08, 6'h23, 6'h2b};
    swp_op  = '{6'h05, 6'h06, 6'h07};
    // Taken bit indexed by {zero,gt}: BNE, BLE, BGT.
    swp_tk  = '{4'b0011, 4'b1101, 4'b1010};

    bus.start = 1'b0; bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.gt = 1'b0;

    // Reset held two cycles, then released.
    tick(1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    chk_lit("reset_c0", V_IDLE);
    tick(1'b0, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0);
    chk_lit("reset_c1", V_IDLE);
    tick(1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    chk_lit("reset_release", V_IDLE);

    // ADDI: plain instruction, three cycles.
    tick(1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'h08, 6'h00, 1'b0, 1'b0);
    chk_lit("addi_c1", V_FETCH);
    tick(1'b1, 1'b0, 6'h08, 6'h00, 1'b0, 1'b0);
    chk_lit("addi_c2", V_DECODE);
    tick(1'b1, 1'b0, 6'h08, 6'h00, 1'b0, 1'b0);
    chk_lit("addi_c3_done", V_DONE);
    tick(1'b1, 1'b0, 6'h08, 6'h00, 1'b0, 1'b0);
    chk_lit("addi_idle", V_IDLE);

    run_flow("beq_z1", 6'h04, 6'h00, 1'b1, 1'b0, V_BR_T);
    run_flow("beq_z0", 6'h04, 6'h00, 1'b0, 1'b1, V_BR_N);

    // BNE/BLE/BGT over all four flag combinations.
    for (int i = 0; i < 3; i++) begin
      tk = swp_tk[i];
      for (int zg = 0; zg < 4; zg++) begin
        run_flow($sformatf("sweep_op%h_zg%0d", swp_op[i], zg), swp_op[i], 6'h00,
                 zg[1], zg[0], tk[zg] ? V_BR_T : V_BR_N);
      end
    end

    run_flow("jump", 6'h02, 6'h00, 1'b0, 1'b0, V_JUMP);
    run_flow("jal", 6'h03, 6'h00, 1'b1, 1'b1, V_JUMP);
    run_flow("jr", 6'h00, 6'h08, 1'b0, 1'b0, V_JR);

    // start held high: DONE goes straight to FETCH.
    tick(1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    chk_lit("b2b_done", V_DONE);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    chk_lit("b2b_fetch", V_FETCH);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    chk_lit("b2b_idle", V_IDLE);

    // start pulsed during DECODE is ignored.
    tick(1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    chk_lit("ign_decode", V_DECODE);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    chk_lit("ign_done", V_DONE);
    tick(1'b1, 1'b0, 6'h23, 6'h00, 1'b0, 1'b0);
    chk_lit("ign_idle", V_IDLE);

    // Reset asserted in BRANCH with the branch condition true.
    tick(1'b1, 1'b1, 6'h04, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'h04, 6'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'h04, 6'h00, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 6'h04, 6'h00, 1'b1, 1'b0);
    chk_lit("rst_branch", V_IDLE);
    tick(1'b1, 1'b0, 6'h04, 6'h00, 1'b1, 1'b0);
    chk_lit("rst_branch_after", V_IDLE);

    // Randomized stream; opcode/funct only change outside DECODE..execute.
    op = 6'h08;
    fn = 6'h00;
    for (int n = 0; n < 3000; n++) begin
      if (m_pos == 0 || m_pos == 1 || m_pos == m_len) begin
        op = op_pool[$urandom_range(0, 9)];
        fn = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      end
      st = ($urandom_range(0, 9) < 4);
      rn = ($urandom_range(0, 63) != 0);
      tick(rn, st, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
